video_timing_gen_param: RTL and testbench

- Parametrised successor to the fixed-720p video signal generator in the HDMI output path, clocked by the pixel clock.
- Produces the same raster signals consumed by the renderer and the TMDS encoders: counters, syncs, active-draw, new-frame and frame counter.
- Adds arbitrary timing, configurable sync polarity, a pixel-enable (freeze) input and a lookahead coordinate port so pipelined renderers can start N cycles early.

---
 rtl/video_timing_gen_param.sv | 155 +++++++++++++++
 tb/tb_video_timing_gen_param.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen_param.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen_param
//  Description : Parametrised raster timing generator for the pixel-clock
//                domain. Produces pixel/line counters, sync pulses with
//                selectable polarity, active-draw, a one-cycle new-frame
//                pulse, a frame counter, and a copy of the position that
//                runs LOOKAHEAD pixels ahead for pipelined renderers.
//  Ports       : clk_pixel_in      - pixel clock
//                rst_in            - synchronous active-high reset
//                en_in             - advance enable (low = freeze raster)
//                hcount_out        - current pixel column
//                vcount_out        - current line
//                hs_out / vs_out   - syncs, polarity from HS_POL / VS_POL
//                ad_out            - active draw
//                nf_out            - new-frame pulse
//                fc_out            - frame counter, 0..FPS-1
//                hcount_early_out  - column LOOKAHEAD clocks ahead
//                vcount_early_out  - line LOOKAHEAD clocks ahead
//                ad_early_out      - active draw for the early position
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen_param #(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 110,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 220,
    parameter int V_ACTIVE  = 720,
    parameter int V_FP      = 5,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter int HS_POL    = 1,
    parameter int VS_POL    = 1,
    parameter int FPS       = 60,
    parameter int LOOKAHEAD = 2,
    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int c_HW      = $clog2(c_H_TOTAL),
    localparam int c_VW      = $clog2(c_V_TOTAL),
    localparam int c_FW      = $clog2(FPS)
) (
    input  logic            clk_pixel_in,
    input  logic            rst_in,
    input  logic            en_in,
    output logic [c_HW-1:0] hcount_out,
    output logic [c_VW-1:0] vcount_out,
    output logic            hs_out,
    output logic            vs_out,
    output logic            ad_out,
    output logic            nf_out,
    output logic [c_FW-1:0] fc_out,
    output logic [c_HW-1:0] hcount_early_out,
    output logic [c_VW-1:0] vcount_early_out,
    output logic            ad_early_out
);

    // Reset position of the early pair: (0,0) advanced by LOOKAHEAD pixels.
    localparam int c_EH_RST = LOOKAHEAD % c_H_TOTAL;
    localparam int c_EV_RST = (LOOKAHEAD / c_H_TOTAL) % c_V_TOTAL;

    // Window test done at 32 bits so a window ending exactly at the total
    // does not alias to zero in the narrow counter width.
    function automatic logic in_win(input logic [31:0] x, input logic [31:0] lo,
                                    input logic [31:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

    logic [c_HW-1:0] r_h;
    logic [c_VW-1:0] r_v;
    logic [c_FW-1:0] r_fc;
    logic            r_nf;

    logic            w_h_wrap;
    logic [c_HW-1:0] w_h_nxt;
    logic [c_VW-1:0] w_v_nxt;
    logic            w_nf_nxt;
    logic            w_hs_on;
    logic            w_vs_on;
    logic [c_HW-1:0] w_eh;
    logic [c_VW-1:0] w_ev;

    assign w_h_wrap = (r_h == c_HW'(c_H_TOTAL - 1));
    assign w_h_nxt  = w_h_wrap ? '0 : r_h + c_HW'(1);
    assign w_v_nxt  = !w_h_wrap ? r_v :
                      ((r_v == c_VW'(c_V_TOTAL - 1)) ? '0 : r_v + c_VW'(1));
    // The frame boundary is the first blanking pixel after the last active line.
    assign w_nf_nxt = (w_h_nxt == c_HW'(H_ACTIVE)) && (w_v_nxt == c_VW'(V_ACTIVE));

    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            r_h  <= '0;
            r_v  <= '0;
            r_fc <= '0;
            r_nf <= 1'b0;
        end else if (en_in) begin
            r_h  <= w_h_nxt;
            r_v  <= w_v_nxt;
            r_nf <= w_nf_nxt;
            if (w_nf_nxt) begin
                r_fc <= (r_fc == c_FW'(FPS - 1)) ? '0 : r_fc + c_FW'(1);
            end
        end else begin
            r_nf <= 1'b0;
        end
    end

    generate
        if (LOOKAHEAD == 0) begin : g_early_same
            assign w_eh = r_h;
            assign w_ev = r_v;
        end else begin : g_early_lead
            logic [c_HW-1:0] r_eh;
            logic [c_VW-1:0] r_ev;
            logic            w_eh_wrap;

            assign w_eh_wrap = (r_eh == c_HW'(c_H_TOTAL - 1));

            always_ff @(posedge clk_pixel_in) begin
                if (rst_in) begin
                    r_eh <= c_HW'(c_EH_RST);
                    r_ev <= c_VW'(c_EV_RST);
                end else if (en_in) begin
                    r_eh <= w_eh_wrap ? '0 : r_eh + c_HW'(1);
                    if (w_eh_wrap) begin
                        r_ev <= (r_ev == c_VW'(c_V_TOTAL - 1)) ? '0 : r_ev + c_VW'(1);
                    end
                end
            end

            assign w_eh = r_eh;
            assign w_ev = r_ev;
        end
    endgenerate

    // Decodes are taken straight from the counter registers so every output
    // lines up with the position it describes; rst_in masks them while held.
    assign w_hs_on = !rst_in && in_win(32'(r_h), 32'(H_ACTIVE + H_FP),
                                       32'(H_ACTIVE + H_FP + H_SYNC));
    assign w_vs_on = !rst_in && in_win(32'(r_v), 32'(V_ACTIVE + V_FP),
                                       32'(V_ACTIVE + V_FP + V_SYNC));

    assign hcount_out       = r_h;
    assign vcount_out       = r_v;
    assign hs_out           = (HS_POL != 0) ? w_hs_on : !w_hs_on;
    assign vs_out           = (VS_POL != 0) ? w_vs_on : !w_vs_on;
    assign ad_out           = !rst_in && (32'(r_h) < 32'(H_ACTIVE)) && (32'(r_v) < 32'(V_ACTIVE));
    // A frozen raster must not repeat the frame pulse.
    assign nf_out           = r_nf && en_in && !rst_in;
    assign fc_out           = r_fc;
    assign hcount_early_out = w_eh;
    assign vcount_early_out = w_ev;
    assign ad_early_out     = !rst_in && (32'(w_eh) < 32'(H_ACTIVE)) && (32'(w_ev) < 32'(V_ACTIVE));

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_gen_param
//  Description : Self-checking bench for video_timing_gen_param. Two small
//                rasters (both sync polarities) and the default 720p raster
//                run from shared stimulus against a position-index model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen_param;

    localparam int c_SHT = 14;
    localparam int c_SVT = 7;
    localparam int c_SN  = c_SHT * c_SVT;
    localparam int c_SNF = 4 * c_SHT + 8;
    localparam int c_CHT = 1650;
    localparam int c_CVT = 750;
    localparam int c_CN  = c_CHT * c_CVT;
    localparam int c_CNF = 720 * c_CHT + 1280;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic [3:0]  w_ha, w_hea, w_hb, w_heb;
    logic [2:0]  w_va, w_vea, w_vb, w_veb;
    logic [1:0]  w_fca, w_fcb;
    logic        w_hsa, w_vsa, w_ada, w_nfa, w_adea;
    logic        w_hsb, w_vsb, w_adb, w_nfb, w_adeb;
    logic [10:0] w_hc, w_hec;
    logic [9:0]  w_vc, w_vec;
    logic [5:0]  w_fcc;
    logic        w_hsc, w_vsc, w_adc, w_nfc, w_adec;

    video_timing_gen_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .FPS(3), .LOOKAHEAD(2)
    ) u_dut_a (
        .clk_pixel_in(clk), .rst_in(rst), .en_in(en),
        .hcount_out(w_ha), .vcount_out(w_va), .hs_out(w_hsa), .vs_out(w_vsa),
        .ad_out(w_ada), .nf_out(w_nfa), .fc_out(w_fca),
        .hcount_early_out(w_hea), .vcount_early_out(w_vea), .ad_early_out(w_adea)
    );

    video_timing_gen_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(0), .VS_POL(0), .FPS(3), .LOOKAHEAD(2)
    ) u_dut_b (
        .clk_pixel_in(clk), .rst_in(rst), .en_in(en),
        .hcount_out(w_hb), .vcount_out(w_vb), .hs_out(w_hsb), .vs_out(w_vsb),
        .ad_out(w_adb), .nf_out(w_nfb), .fc_out(w_fcb),
        .hcount_early_out(w_heb), .vcount_early_out(w_veb), .ad_early_out(w_adeb)
    );

    video_timing_gen_param u_dut_c (
        .clk_pixel_in(clk), .rst_in(rst), .en_in(en),
        .hcount_out(w_hc), .vcount_out(w_vc), .hs_out(w_hsc), .vs_out(w_vsc),
        .ad_out(w_adc), .nf_out(w_nfc), .fc_out(w_fcc),
        .hcount_early_out(w_hec), .vcount_early_out(w_vec), .ad_early_out(w_adec)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: raster position as a linear pixel index per frame.
    int pa = 0, fca = 0, pc = 0, fcc = 0;
    bit nfa = 1'b0, nfc = 1'b0;

    int cnt_ad, cnt_nf, cnt_hs, fc_before;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic mstep(input bit r, input bit e, input int n, input int nfpos,
                         input int fps, inout int p, inout int fc, inout bit nf);
        if (r) begin
            p = 0; fc = 0; nf = 1'b0;
        end else if (e) begin
            p  = (p + 1) % n;
            nf = (p == nfpos);
            if (nf) fc = (fc + 1) % fps;
        end else begin
            nf = 1'b0;
        end
    endtask

    task automatic check_all();
        int h, v, eh, ev, pe;
        bit hs, vs, ad, ade;
        // small rasters
        h = pa % c_SHT; v = pa / c_SHT;
        pe = (pa + 2) % c_SN; eh = pe % c_SHT; ev = pe / c_SHT;
        hs  = !rst && h >= 10 && h < 12;
        vs  = !rst && v == 5;
        ad  = !rst && h < 8 && v < 4;
        ade = !rst && eh < 8 && ev < 4;
        chk("a_h", 32'(w_ha), h);   chk("a_v", 32'(w_va), v);
        chk("a_hs", 32'(w_hsa), 32'(hs)); chk("a_vs", 32'(w_vsa), 32'(vs));
        chk("a_ad", 32'(w_ada), 32'(ad));
        chk("a_nf", 32'(w_nfa), 32'(nfa && en && !rst));
        chk("a_fc", 32'(w_fca), fca);
        chk("a_he", 32'(w_hea), eh); chk("a_ve", 32'(w_vea), ev);
        chk("a_ade", 32'(w_adea), 32'(ade));
        chk("b_h", 32'(w_hb), h);   chk("b_v", 32'(w_vb), v);
        chk("b_hs", 32'(w_hsb), 32'(!hs)); chk("b_vs", 32'(w_vsb), 32'(!vs));
        chk("b_ad", 32'(w_adb), 32'(ad));
        chk("b_nf", 32'(w_nfb), 32'(nfa && en && !rst));
        chk("b_fc", 32'(w_fcb), fca);
        chk("b_he", 32'(w_heb), eh); chk("b_ve", 32'(w_veb), ev);
        chk("b_ade", 32'(w_adeb), 32'(ade));
        // 720p raster
        h = pc % c_CHT; v = pc / c_CHT;
        pe = (pc + 2) % c_CN; eh = pe % c_CHT; ev = pe / c_CHT;
        chk("c_h", 32'(w_hc), h);   chk("c_v", 32'(w_vc), v);
        chk("c_hs", 32'(w_hsc), 32'(!rst && h >= 1390 && h < 1430));
        chk("c_vs", 32'(w_vsc), 32'(!rst && v >= 725 && v < 730));
        chk("c_ad", 32'(w_adc), 32'(!rst && h < 1280 && v < 720));
        chk("c_nf", 32'(w_nfc), 32'(nfc && en && !rst));
        chk("c_fc", 32'(w_fcc), fcc);
        chk("c_he", 32'(w_hec), eh); chk("c_ve", 32'(w_vec), ev);
        chk("c_ade", 32'(w_adec), 32'(!rst && eh < 1280 && ev < 720));
    endtask

    // One clock: apply inputs, check the current cycle, then advance the model.
    task automatic tick(input bit r, input bit e);
        rst = r; en = e;
        #1;
        check_all();
        @(posedge clk);
        mstep(r, e, c_SN, c_SNF, 3, pa, fca, nfa);
        mstep(r, e, c_CN, c_CNF, 60, pc, fcc, nfc);
        #1;
    endtask

    task automatic goto_pos(input int h, input int v);
        for (int i = 0; i < 2 * c_SN && pa != v * c_SHT + h; i++) tick(1'b0, 1'b1);
        rst = 1'b0; en = 1'b1; #1;
        chk("goto_h", 32'(w_ha), h);
        chk("goto_v", 32'(w_va), v);
    endtask

    initial begin
        // Establish reset state.
        rst = 1'b1; en = 1'b0;
        repeat (3) @(posedge clk);
        mstep(1'b1, 1'b0, c_SN, c_SNF, 3, pa, fca, nfa);
        mstep(1'b1, 1'b0, c_CN, c_CNF, 60, pc, fcc, nfc);
        #1;
        tick(1'b1, 1'b1);

        // Three full small frames with en held high.
        cnt_ad = 0; cnt_nf = 0;
        for (int i = 0; i < 3 * c_SN; i++) begin
            rst = 1'b0; en = 1'b1; #1;
            cnt_ad += int'(w_ada);
            cnt_nf += int'(w_nfa);
            #0;
            tick(1'b0, 1'b1);
        end
        chk("ad_cycles_3frames", 32'(cnt_ad), 96);
        chk("nf_pulses_3frames", 32'(cnt_nf), 3);
        chk("fc_after_3frames", 32'(w_fca), 0);

        // Freeze just before the new-frame edge.
        goto_pos(7, 4);
        fc_before = int'(w_fca);
        cnt_nf = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0);
            cnt_nf += int'(w_nfa);
        end
        chk("hold_h", 32'(w_ha), 7);
        for (int i = 0; i < 20; i++) begin
            rst = 1'b0; en = 1'b1; #1;
            cnt_nf += int'(w_nfa);
            tick(1'b0, 1'b1);
        end
        chk("hold_nf_once", 32'(cnt_nf), 1);
        chk("hold_fc_step", 32'(w_fca), (fc_before + 1) % 3);

        // Early-port wrap across the frame boundary.
        goto_pos(12, 6);
        chk("wrap_he", 32'(w_hea), 0);
        chk("wrap_ve", 32'(w_vea), 0);
        chk("wrap_ade", 32'(w_adea), 1);
        tick(1'b0, 1'b1);
        rst = 1'b0; en = 1'b1; #1;
        chk("wrap_he2", 32'(w_hea), 1);

        // Mid-frame reset with fc=1.
        goto_pos(5, 2);
        chk("pre_rst_fc", 32'(w_fca), 1);
        tick(1'b1, 1'b1);
        rst = 1'b0; en = 1'b1; #1;
        chk("rst_h", 32'(w_ha), 0);
        chk("rst_fc", 32'(w_fca), 0);
        chk("rst_ad", 32'(w_ada), 1);
        chk("rst_he", 32'(w_hea), 2);
        chk("rst_ve", 32'(w_vea), 0);

        // Randomised enable and occasional reset.
        for (int i = 0; i < 600; i++) begin
            tick(($urandom % 64) == 0, ($urandom % 4) != 0);
        end

        // 720p: two lines from reset to cover the horizontal sync window.
        tick(1'b1, 1'b1);
        cnt_hs = 0;
        for (int i = 0; i < 3400; i++) begin
            rst = 1'b0; en = 1'b1; #1;
            if (i < c_CHT) cnt_hs += int'(w_hsc);
            tick(1'b0, 1'b1);
        end
        chk("c_hs_width_line0", 32'(cnt_hs), 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
